// File: rtl/gpp_stack_pkg.sv
// ---------------------------------------------------------------------------
// gpp_stack_pkg
// Shared definitions for the hardware stack unit that sits in front of the
// general purpose register file.
//   DEFAULT_DATA_WIDTH       default width of one stack entry
//   DEFAULT_ADDR_WIDTH_STACK default log2 of the stack depth
//   stack_op_t               operation decoded from the {push, pop} pair
//   decode_op()              maps {push, pop} onto stack_op_t
// ---------------------------------------------------------------------------
package gpp_stack_pkg;

    localparam int DEFAULT_DATA_WIDTH       = 16;
    localparam int DEFAULT_ADDR_WIDTH_STACK = 4;

    // The encoding is the raw {push, pop} pair, so decoding is a plain cast.
    typedef enum logic [1:0] {
        STACK_IDLE    = 2'b00,
        STACK_POP     = 2'b01,
        STACK_PUSH    = 2'b10,
        STACK_REPLACE = 2'b11
    } stack_op_t;

    function automatic stack_op_t decode_op(input logic push, input logic pop);
        return stack_op_t'({push, pop});
    endfunction

endpackage : gpp_stack_pkg

// File: rtl/stack_memory.sv
// ---------------------------------------------------------------------------
// stack_memory
// Storage array for the hardware stack: 2**ADDR_WIDTH x DATA_WIDTH entries,
// synchronous write, combinational read. Contents are not reset.
//   clk_i    rising-edge clock
//   we_i     write enable
//   waddr_i  write address
//   wdata_i  write data
//   raddr_i  read address
//   rdata_o  read data (combinational from raddr_i)
// ---------------------------------------------------------------------------
module stack_memory #(
    parameter int DATA_WIDTH = 16,
    parameter int ADDR_WIDTH = 4
) (
    input  logic                  clk_i,
    input  logic                  we_i,
    input  logic [ADDR_WIDTH-1:0] waddr_i,
    input  logic [DATA_WIDTH-1:0] wdata_i,
    input  logic [ADDR_WIDTH-1:0] raddr_i,
    output logic [DATA_WIDTH-1:0] rdata_o
);

    logic [DATA_WIDTH-1:0] mem_q [2**ADDR_WIDTH];

    always_ff @(posedge clk_i) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    assign rdata_o = mem_q[raddr_i];

endmodule : stack_memory

// File: rtl/hardware_stack_unit.sv
// ---------------------------------------------------------------------------
// hardware_stack_unit
// LIFO call/data stack feeding register 0 of the register file through the
// file's stack write port.
//   clk                        rising-edge clock
//   reset_n                    asynchronous active-low reset
//   push / pop                 requests, sampled on the rising edge
//   push_data                  value to push
//   clear_error                synchronously clears the sticky error flags
//   stack_write_enable         one-cycle strobe, the cycle after an accepted pop
//   stack_register_write_data  popped value; holds while the strobe is low
//   stack_count                number of stored entries
//   full / empty               combinational from the stack pointer
//   overflow / underflow       sticky error flags
//
// Request semantics: push and pop are level requests with no back-pressure.
// Each one is acted on in the cycle it is sampled high; a request that would
// cross a boundary (push while full, pop while empty) is dropped and recorded
// in the matching sticky flag instead. push and pop together always produce
// a strobe and never an error.
// ---------------------------------------------------------------------------
module hardware_stack_unit
    import gpp_stack_pkg::*;
#(
    parameter int DATA_WIDTH       = DEFAULT_DATA_WIDTH,
    parameter int ADDR_WIDTH_STACK = DEFAULT_ADDR_WIDTH_STACK
) (
    input  logic                        clk,
    input  logic                        reset_n,
    input  logic                        push,
    input  logic                        pop,
    input  logic [DATA_WIDTH-1:0]       push_data,
    input  logic                        clear_error,
    output logic                        stack_write_enable,
    output logic [DATA_WIDTH-1:0]       stack_register_write_data,
    output logic [ADDR_WIDTH_STACK:0]   stack_count,
    output logic                        full,
    output logic                        empty,
    output logic                        overflow,
    output logic                        underflow
);

    localparam int                        DEPTH   = 2**ADDR_WIDTH_STACK;
    localparam logic [ADDR_WIDTH_STACK:0] SP_FULL = (ADDR_WIDTH_STACK+1)'(DEPTH);
    localparam logic [ADDR_WIDTH_STACK:0] SP_ONE  = (ADDR_WIDTH_STACK+1)'(1);

    // sp counts stored entries (one extra bit so "full" is representable);
    // the top entry lives at mem[sp-1].
    logic [ADDR_WIDTH_STACK:0]   sp_q, sp_d;
    logic [ADDR_WIDTH_STACK:0]   sp_m1;
    logic                        strobe_q, strobe_d;
    logic [DATA_WIDTH-1:0]       data_q, data_d;
    logic                        ovf_q, ovf_d;
    logic                        unf_q, unf_d;
    logic                        ovf_evt, unf_evt;
    logic                        is_full, is_empty;
    stack_op_t                   op;

    logic                        mem_we;
    logic [ADDR_WIDTH_STACK-1:0] mem_waddr;
    logic [ADDR_WIDTH_STACK-1:0] top_addr;
    logic [DATA_WIDTH-1:0]       top_data;

    assign op       = decode_op(push, pop);
    assign is_full  = (sp_q == SP_FULL);
    assign is_empty = (sp_q == '0);
    assign sp_m1    = sp_q - SP_ONE;
    // Only consumed when the stack is non-empty, so the wrap at sp=0 is harmless.
    assign top_addr = sp_m1[ADDR_WIDTH_STACK-1:0];

    stack_memory #(
        .DATA_WIDTH (DATA_WIDTH),
        .ADDR_WIDTH (ADDR_WIDTH_STACK)
    ) u_stack_memory (
        .clk_i   (clk),
        .we_i    (mem_we),
        .waddr_i (mem_waddr),
        .wdata_i (push_data),
        .raddr_i (top_addr),
        .rdata_o (top_data)
    );

    always_comb begin
        sp_d      = sp_q;
        strobe_d  = 1'b0;
        data_d    = data_q;
        ovf_evt   = 1'b0;
        unf_evt   = 1'b0;
        mem_we    = 1'b0;
        mem_waddr = sp_q[ADDR_WIDTH_STACK-1:0];

        unique case (op)
            STACK_PUSH: begin
                if (is_full) begin
                    ovf_evt = 1'b1;
                end else begin
                    mem_we = 1'b1;
                    sp_d   = sp_q + SP_ONE;
                end
            end
            STACK_POP: begin
                if (is_empty) begin
                    unf_evt = 1'b1;
                end else begin
                    data_d   = top_data;
                    strobe_d = 1'b1;
                    sp_d     = sp_m1;
                end
            end
            STACK_REPLACE: begin
                strobe_d = 1'b1;
                if (is_empty) begin
                    // Nothing stored: the pushed value passes straight through.
                    data_d = push_data;
                end else begin
                    // Return the old top and overwrite it in place; depth unchanged.
                    data_d    = top_data;
                    mem_we    = 1'b1;
                    mem_waddr = top_addr;
                end
            end
            default: begin
            end
        endcase

        // A new error in the same cycle as clear_error keeps the flag set.
        ovf_d = (ovf_q & ~clear_error) | ovf_evt;
        unf_d = (unf_q & ~clear_error) | unf_evt;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sp_q     <= '0;
            strobe_q <= 1'b0;
            data_q   <= '0;
            ovf_q    <= 1'b0;
            unf_q    <= 1'b0;
        end else begin
            sp_q     <= sp_d;
            strobe_q <= strobe_d;
            data_q   <= data_d;
            ovf_q    <= ovf_d;
            unf_q    <= unf_d;
        end
    end

    assign stack_write_enable        = strobe_q;
    assign stack_register_write_data = data_q;
    assign stack_count               = sp_q;
    assign full                      = is_full;
    assign empty                     = is_empty;
    assign overflow                  = ovf_q;
    assign underflow                 = unf_q;

endmodule : hardware_stack_unit

// File: tb/tb_hardware_stack_unit.sv
module tb_hardware_stack_unit;

  localparam int DW    = 16;
  localparam int AW    = 4;
  localparam int DEPTH = 16;

  logic          clk;
  logic          reset_n;
  logic          push;
  logic          pop;
  logic [DW-1:0] push_data;
  logic          clear_error;
  logic          stack_write_enable;
  logic [DW-1:0] stack_register_write_data;
  logic [AW:0]   stack_count;
  logic          full;
  logic          empty;
  logic          overflow;
  logic          underflow;

  int total = 0;
  int bad   = 0;

  // Reference model: a plain LIFO queue plus the expected output registers.
  logic [DW-1:0] exp_q[$];
  logic          exp_we;
  logic [DW-1:0] exp_data;
  logic          exp_ovf;
  logic          exp_unf;

  // Register 0 of a register file wired to the stack write port.
  logic [DW-1:0] reg0;

  hardware_stack_unit #(.DATA_WIDTH(DW), .ADDR_WIDTH_STACK(AW)) dut (
    .clk                       (clk),
    .reset_n                   (reset_n),
    .push                      (push),
    .pop                       (pop),
    .push_data                 (push_data),
    .clear_error               (clear_error),
    .stack_write_enable        (stack_write_enable),
    .stack_register_write_data (stack_register_write_data),
    .stack_count               (stack_count),
    .full                      (full),
    .empty                     (empty),
    .overflow                  (overflow),
    .underflow                 (underflow)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) reg0 <= '0;
    else if (stack_write_enable) reg0 <= stack_register_write_data;
  end

  task automatic model_reset();
    exp_q.delete();
    exp_we   = 1'b0;
    exp_data = '0;
    exp_ovf  = 1'b0;
    exp_unf  = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    push = 0; pop = 0; push_data = '0; clear_error = 0;
    reset_n = 1'b0;
    #3;
    reset_n = 1'b1;
    model_reset();
  endtask

  // ---------------- driver ----------------
  // Drives one request cycle, advances the model, returns #1 after the edge.
  task automatic do_cycle(input logic p, input logic po, input logic [DW-1:0] d, input logic c);
    logic ovf_evt, unf_evt;
    @(negedge clk);
    push = p; pop = po; push_data = d; clear_error = c;
    ovf_evt = 1'b0;
    unf_evt = 1'b0;
    exp_we  = 1'b0;
    if (p && po) begin
      exp_we = 1'b1;
      if (exp_q.size() == 0) exp_data = d;
      else begin
        exp_data = exp_q[exp_q.size()-1];
        exp_q[exp_q.size()-1] = d;
      end
    end else if (p) begin
      if (exp_q.size() == DEPTH) ovf_evt = 1'b1;
      else exp_q.push_back(d);
    end else if (po) begin
      if (exp_q.size() == 0) unf_evt = 1'b1;
      else begin
        exp_data = exp_q.pop_back();
        exp_we   = 1'b1;
      end
    end
    exp_ovf = (c ? 1'b0 : exp_ovf) | ovf_evt;
    exp_unf = (c ? 1'b0 : exp_unf) | unf_evt;
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    do_cycle(1'b0, 1'b0, '0, 1'b0);
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    do_reset();
    #1;
    total++; if (stack_count !== 5'd0) begin bad++; $display("FAIL reset_count got=%0d exp=0", stack_count); end
    total++; if (empty !== 1'b1) begin bad++; $display("FAIL reset_empty got=%b exp=1", empty); end
    total++; if (full !== 1'b0) begin bad++; $display("FAIL reset_full got=%b exp=0", full); end
    total++; if (stack_write_enable !== 1'b0) begin bad++; $display("FAIL reset_we got=%b exp=0", stack_write_enable); end
    total++; if (stack_register_write_data !== 16'h0) begin bad++; $display("FAIL reset_data got=%h exp=0000", stack_register_write_data); end
    total++; if (overflow !== 1'b0) begin bad++; $display("FAIL reset_ovf got=%b exp=0", overflow); end
    total++; if (underflow !== 1'b0) begin bad++; $display("FAIL reset_unf got=%b exp=0", underflow); end
  endtask

  task automatic test_push_three();
    logic [DW-1:0] vals[3];
    vals[0] = 16'h1111; vals[1] = 16'h2222; vals[2] = 16'h3333;
    do_reset();
    for (int i = 0; i < 3; i++) begin
      do_cycle(1'b1, 1'b0, vals[i], 1'b0);
      total++; if (stack_write_enable !== 1'b0) begin bad++; $display("FAIL push3_we[%0d] got=%b exp=0", i, stack_write_enable); end
    end
    total++; if (stack_count !== 5'd3) begin bad++; $display("FAIL push3_count got=%0d exp=3", stack_count); end
    total++; if (empty !== 1'b0) begin bad++; $display("FAIL push3_empty got=%b exp=0", empty); end
  endtask

  task automatic test_pop_three();
    logic [DW-1:0] vals[3];
    vals[0] = 16'h3333; vals[1] = 16'h2222; vals[2] = 16'h1111;
    for (int i = 0; i < 3; i++) begin
      do_cycle(1'b0, 1'b1, '0, 1'b0);
      total++; if (stack_write_enable !== 1'b1) begin bad++; $display("FAIL pop3_we[%0d] got=%b exp=1", i, stack_write_enable); end
      total++; if (stack_register_write_data !== vals[i]) begin bad++; $display("FAIL pop3_data[%0d] got=%h exp=%h", i, stack_register_write_data, vals[i]); end
    end
    idle();
    total++; if (stack_write_enable !== 1'b0) begin bad++; $display("FAIL pop3_we_after got=%b exp=0", stack_write_enable); end
    total++; if (stack_register_write_data !== 16'h1111) begin bad++; $display("FAIL pop3_data_hold got=%h exp=1111", stack_register_write_data); end
    total++; if (empty !== 1'b1) begin bad++; $display("FAIL pop3_empty got=%b exp=1", empty); end
    total++; if (stack_count !== 5'd0) begin bad++; $display("FAIL pop3_count got=%0d exp=0", stack_count); end
  endtask

  task automatic test_full_overflow();
    do_reset();
    for (int i = 0; i < DEPTH; i++) do_cycle(1'b1, 1'b0, DW'(i), 1'b0);
    total++; if (full !== 1'b1) begin bad++; $display("FAIL full_flag got=%b exp=1", full); end
    total++; if (overflow !== 1'b0) begin bad++; $display("FAIL full_no_ovf got=%b exp=0", overflow); end
    do_cycle(1'b1, 1'b0, 16'hDEAD, 1'b0);
    total++; if (overflow !== 1'b1) begin bad++; $display("FAIL ovf_set got=%b exp=1", overflow); end
    total++; if (stack_count !== 5'd16) begin bad++; $display("FAIL ovf_count got=%0d exp=16", stack_count); end
    do_cycle(1'b0, 1'b1, '0, 1'b0);
    total++; if (stack_write_enable !== 1'b1 || stack_register_write_data !== 16'h000F) begin
      bad++; $display("FAIL ovf_pop got=%b/%h exp=1/000f", stack_write_enable, stack_register_write_data); end
    total++; if (overflow !== 1'b1) begin bad++; $display("FAIL ovf_sticky got=%b exp=1", overflow); end
    do_cycle(1'b0, 1'b0, '0, 1'b1);
    total++; if (overflow !== 1'b0) begin bad++; $display("FAIL ovf_clear got=%b exp=0", overflow); end
    // Refill, then overflow in the same cycle as clear_error: error wins.
    do_cycle(1'b1, 1'b0, 16'h0F0F, 1'b0);
    do_cycle(1'b1, 1'b0, 16'hBAD0, 1'b1);
    total++; if (overflow !== 1'b1) begin bad++; $display("FAIL ovf_clear_race got=%b exp=1", overflow); end
    // Push+pop while full replaces the top with no overflow.
    do_cycle(1'b0, 1'b0, '0, 1'b1);
    do_cycle(1'b1, 1'b1, 16'h7777, 1'b0);
    total++; if (stack_register_write_data !== 16'h0F0F || overflow !== 1'b0 || stack_count !== 5'd16) begin
      bad++; $display("FAIL full_replace got=%h/%b/%0d exp=0f0f/0/16", stack_register_write_data, overflow, stack_count); end
    do_cycle(1'b0, 1'b1, '0, 1'b0);
    total++; if (stack_register_write_data !== 16'h7777) begin bad++; $display("FAIL full_replace_pop got=%h exp=7777", stack_register_write_data); end
  endtask

  task automatic test_underflow_bypass();
    do_reset();
    do_cycle(1'b0, 1'b1, '0, 1'b0);
    total++; if (underflow !== 1'b1) begin bad++; $display("FAIL unf_set got=%b exp=1", underflow); end
    total++; if (stack_write_enable !== 1'b0) begin bad++; $display("FAIL unf_we got=%b exp=0", stack_write_enable); end
    do_cycle(1'b1, 1'b1, 16'hBEEF, 1'b0);
    total++; if (stack_write_enable !== 1'b1 || stack_register_write_data !== 16'hBEEF) begin
      bad++; $display("FAIL bypass got=%b/%h exp=1/beef", stack_write_enable, stack_register_write_data); end
    total++; if (stack_count !== 5'd0 || empty !== 1'b1) begin bad++; $display("FAIL bypass_count got=%0d exp=0", stack_count); end
    total++; if (underflow !== 1'b1) begin bad++; $display("FAIL bypass_unf got=%b exp=1", underflow); end
    do_cycle(1'b0, 1'b0, '0, 1'b1);
    total++; if (underflow !== 1'b0) begin bad++; $display("FAIL unf_clear got=%b exp=0", underflow); end
  endtask

  task automatic test_replace();
    do_reset();
    do_cycle(1'b1, 1'b0, 16'h00AA, 1'b0);
    do_cycle(1'b1, 1'b0, 16'h00BB, 1'b0);
    do_cycle(1'b1, 1'b1, 16'h00CC, 1'b0);
    total++; if (stack_write_enable !== 1'b1 || stack_register_write_data !== 16'h00BB) begin
      bad++; $display("FAIL replace got=%b/%h exp=1/00bb", stack_write_enable, stack_register_write_data); end
    total++; if (stack_count !== 5'd2) begin bad++; $display("FAIL replace_count got=%0d exp=2", stack_count); end
    do_cycle(1'b0, 1'b1, '0, 1'b0);
    total++; if (stack_register_write_data !== 16'h00CC) begin bad++; $display("FAIL replace_pop got=%h exp=00cc", stack_register_write_data); end
    do_cycle(1'b0, 1'b1, '0, 1'b0);
    total++; if (stack_register_write_data !== 16'h00AA) begin bad++; $display("FAIL replace_pop2 got=%h exp=00aa", stack_register_write_data); end
  endtask

  task automatic test_regfile_and_async_reset();
    do_reset();
    do_cycle(1'b1, 1'b0, 16'h1234, 1'b0);
    do_cycle(1'b0, 1'b1, '0, 1'b0);
    total++; if (reg0 !== 16'h0000) begin bad++; $display("FAIL reg0_early got=%h exp=0000", reg0); end
    idle();
    total++; if (reg0 !== 16'h1234) begin bad++; $display("FAIL reg0_write got=%h exp=1234", reg0); end
    do_cycle(1'b1, 1'b0, 16'h5A5A, 1'b0);
    do_cycle(1'b1, 1'b0, 16'h6B6B, 1'b0);
    do_cycle(1'b0, 1'b1, '0, 1'b0);
    total++; if (stack_write_enable !== 1'b1) begin bad++; $display("FAIL arst_pre_we got=%b exp=1", stack_write_enable); end
    #2;
    reset_n = 1'b0;
    #1;
    total++; if (stack_write_enable !== 1'b0) begin bad++; $display("FAIL arst_we got=%b exp=0", stack_write_enable); end
    total++; if (stack_count !== 5'd0) begin bad++; $display("FAIL arst_count got=%0d exp=0", stack_count); end
    @(negedge clk);
    reset_n = 1'b1;
    model_reset();
    idle();
    total++; if (reg0 !== 16'h0000 || empty !== 1'b1) begin bad++; $display("FAIL arst_after got=%h/%b exp=0000/1", reg0, empty); end
  endtask

  task automatic test_random();
    logic p, po, c;
    logic [DW-1:0] d;
    do_reset();
    for (int i = 0; i < 600; i++) begin
      // Push-heavy, then pop-heavy, then balanced, to reach both boundaries.
      if (i < 200)      begin p = ($urandom_range(0, 9) < 7); po = ($urandom_range(0, 9) < 3); end
      else if (i < 400) begin p = ($urandom_range(0, 9) < 3); po = ($urandom_range(0, 9) < 7); end
      else              begin p = $urandom_range(0, 1); po = $urandom_range(0, 1); end
      c = ($urandom_range(0, 15) == 0);
      d = DW'($urandom);
      do_cycle(p, po, d, c);
      total++;
      if (stack_write_enable !== exp_we || stack_register_write_data !== exp_data ||
          stack_count !== 5'(exp_q.size()) || full !== (exp_q.size() == DEPTH) ||
          empty !== (exp_q.size() == 0) || overflow !== exp_ovf || underflow !== exp_unf) begin
        bad++;
        $display("FAIL rand[%0d] got we=%b d=%h cnt=%0d f=%b e=%b o=%b u=%b exp we=%b d=%h cnt=%0d o=%b u=%b",
                 i, stack_write_enable, stack_register_write_data, stack_count, full, empty,
                 overflow, underflow, exp_we, exp_data, exp_q.size(), exp_ovf, exp_unf);
      end
    end
  endtask

  // ---------------- sequence + report ----------------
  initial begin
    reset_n = 1'b0; push = 0; pop = 0; push_data = '0; clear_error = 0;
    model_reset();
    #12;
    test_reset();
    test_push_three();
    test_pop_three();
    test_full_overflow();
    test_underflow_bypass();
    test_replace();
    test_regfile_and_async_reset();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
